// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing with a one-entry holding register so
// consecutive bytes go out back-to-back with no idle gap between frames.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  input  logic [7:0] data_i,
  output logic       ser_o,
  output logic       busy_o
);

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_IDLE      = 1'b1;

  localparam int unsigned     BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic                stop_cnt;
  logic [7:0]          shift;
  logic [7:0]          hold_data;
  logic                hold_valid;
  logic                bit_end;

  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign data_ready_o = en_i & ~hold_valid & ~rst_i;
  assign busy_o       = (state != S_IDLE) | hold_valid;

  // The accept and the drain of hold_valid never coincide: draining needs
  // hold_valid=1, which already forces data_ready_o low on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      ser_o      <= UART_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      shift      <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (!en_i) begin
      state      <= S_IDLE;
      ser_o      <= UART_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (data_valid_i && data_ready_o) begin
        hold_data  <= data_i;
        hold_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          ser_o    <= UART_IDLE;
          baud_cnt <= '0;
          if (hold_valid) begin
            shift      <= hold_data;
            hold_valid <= 1'b0;
            state      <= S_START;
            ser_o      <= UART_START_BIT;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
            ser_o    <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              stop_cnt <= '0;
              state    <= S_STOP;
              ser_o    <= UART_STOP_BIT;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              ser_o   <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              if (hold_valid) begin
                shift      <= hold_data;
                hold_valid <= 1'b0;
                state      <= S_START;
                ser_o      <= UART_START_BIT;
              end else begin
                state <= S_IDLE;
                ser_o <= UART_IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          ser_o <= UART_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: 8N1 and 8N2 instances at 4 clocks per bit,
// with a sampling line receiver that decodes frames and checks bit timing.
module tb_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       dv_a, dv_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, ready_b, ser_a, ser_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_tx1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_valid_i(dv_a),
    .data_ready_o(ready_a), .data_i(data_a), .ser_o(ser_a), .busy_o(busy_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_tx2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_valid_i(dv_b),
    .data_ready_o(ready_b), .data_i(data_b), .ser_o(ser_b), .busy_o(busy_b)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int unsigned starts_a[$];
  int unsigned starts_b[$];
  int unsigned frames_a = 0;
  int unsigned frames_b = 0;
  bit          mon_en_a = 1'b1;
  bit          mon_en_b = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic line(input int which);
    return (which == 1) ? ser_a : ser_b;
  endfunction

  // Waits for a start bit, then samples every cycle of the frame.
  task automatic rx_frame(input int which, input int sb, output logic [7:0] b,
                          output int unsigned t0, output bit ok_start,
                          output bit ok_width, output bit ok_stop, output bit en_snap);
    logic s, first;
    do @(negedge clk); while (line(which) !== 1'b0);
    t0       = cyc;
    en_snap  = (which == 1) ? mon_en_a : mon_en_b;
    ok_start = 1'b1;
    ok_width = 1'b1;
    ok_stop  = 1'b1;
    b        = '0;
    first    = 1'b0;
    for (int p = 0; p < 9 + sb; p++) begin
      for (int k = 0; k < int'(CPB); k++) begin
        if (!(p == 0 && k == 0)) @(negedge clk);
        s = line(which);
        if (k == 0) first = s;
        else if (s !== first) ok_width = 1'b0;
        if (p == 0 && s !== 1'b0) ok_start = 1'b0;
        if (p >= 9 && s !== 1'b1) ok_stop = 1'b0;
        if (p >= 1 && p <= 8 && k == 0) b[p-1] = s;
      end
    end
  endtask

  task automatic monitor(input int which);
    logic [7:0]  b, exp;
    int unsigned t0;
    bit          os, ow, ost, en_snap, got_exp;
    string       pfx;
    pfx = (which == 1) ? "a" : "b";
    forever begin
      rx_frame(which, (which == 1) ? 1 : 2, b, t0, os, ow, ost, en_snap);
      if (en_snap) begin
        got_exp = 1'b0;
        exp     = '0;
        if (which == 1 && q_a.size() != 0) begin exp = q_a.pop_front(); got_exp = 1'b1; end
        if (which == 2 && q_b.size() != 0) begin exp = q_b.pop_front(); got_exp = 1'b1; end
        chk({pfx, "_frame_expected"}, got_exp, 1);
        if (got_exp) chk({pfx, "_byte"}, b, exp);
        chk({pfx, "_start_bit"}, os, 1);
        chk({pfx, "_bit_width"}, ow, 1);
        chk({pfx, "_stop_bits"}, ost, 1);
        if (which == 1) begin starts_a.push_back(t0); frames_a++; end
        else begin starts_b.push_back(t0); frames_b++; end
      end
    end
  endtask

  initial monitor(1);
  initial monitor(2);

  // Leaves data_valid high; returns the cycle index of the handshake edge.
  task automatic send(input int which, input logic [7:0] b, input bit push,
                      output int unsigned e);
    int unsigned n = 0;
    if (which == 1) begin dv_a = 1'b1; data_a = b; end
    else begin dv_b = 1'b1; data_b = b; end
    while (((which == 1) ? ready_a : ready_b) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", (which == 1) ? ready_a : ready_b, 1);
    if (push) begin
      if (which == 1) q_a.push_back(b);
      else q_b.push_back(b);
    end
    @(negedge clk);
    e = cyc;
  endtask

  task automatic wait_frames(input int which, input int unsigned n);
    int unsigned k = 0;
    while (((which == 1) ? frames_a : frames_b) < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("frames_seen", (which == 1) ? frames_a : frames_b, n);
  endtask

  initial begin : main
    int unsigned e, e1, e2, nb, n, rise, ok_cnt;
    logic        rdy1;
    bit          ser_ok, busy_ok, rdy_ok;

    rst = 1'b1; en = 1'b1; dv_a = 1'b0; dv_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ser_a", ser_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ready_a", ready_a, 0);
    chk("rst_ser_b", ser_b, 1);
    chk("rst_ready_b", ready_b, 0);
    rst = 1'b0;
    #1 chk("rel_ready_a", ready_a, 1);
    @(negedge clk);

    // Single 0xA5 frame
    send(1, 8'hA5, 1'b1, e);
    dv_a = 1'b0;
    chk("a5_ready_while_held", ready_a, 0);
    nb = 0; rdy1 = 1'b0;
    while (busy_a === 1'b1 && nb < 200) begin
      nb++;
      @(negedge clk);
      if (nb == 1) rdy1 = ready_a;
    end
    chk("a5_busy_cycles", nb, 41);
    chk("a5_ready_after_drain", rdy1, 1);
    wait_frames(1, 1);
    chk("a5_latency", starts_a[0], e + 1);

    // Back-to-back 0x00 then 0xFF with data_valid held high
    send(1, 8'h00, 1'b1, e1);
    send(1, 8'hFF, 1'b1, e2);
    dv_a = 1'b0;
    chk("b2b_accept_during_frame", e2 - e1, 2);
    n = 0;
    while (ready_a !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    rise = cyc;
    chk("b2b_ready_low_cycles", n, 39);
    wait_frames(1, 3);
    chk("b2b_latency", starts_a[1], e1 + 1);
    chk("b2b_period", starts_a[2] - starts_a[1], 40);
    chk("b2b_ready_rise_at_start", rise, starts_a[2]);

    // Two stop bits, 0x3C
    send(2, 8'h3C, 1'b1, e);
    dv_b = 1'b0;
    nb = 0;
    while (busy_b === 1'b1 && nb < 200) begin nb++; @(negedge clk); end
    chk("sb2_busy_cycles", nb, 45);
    wait_frames(2, 1);
    chk("sb2_latency", starts_b[0], e + 1);

    // Abort during data bit 3 of 0x55 with 0x99 pending
    repeat (2) @(negedge clk);
    mon_en_a = 1'b0;
    send(1, 8'h55, 1'b0, e);
    send(1, 8'h99, 1'b0, e2);
    dv_a = 1'b0;
    chk("abort_pending_busy", busy_a, 1);
    while (cyc < e + 18) @(negedge clk);
    chk("abort_bit3_level", ser_a, 0);
    en = 1'b0;
    #1 chk("abort_ready_low", ready_a, 0);
    @(negedge clk);
    chk("abort_ser_idle", ser_a, 1);
    chk("abort_busy_low", busy_a, 0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    #1 chk("abort_ready_back", ready_a, 1);
    ok_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ser_a === 1'b1 && busy_a === 1'b0) ok_cnt++;
    end
    chk("abort_pending_dropped", ok_cnt, 40);
    mon_en_a = 1'b1;
    send(1, 8'h12, 1'b1, e);
    dv_a = 1'b0;
    wait_frames(1, 4);
    chk("reenable_latency", starts_a[3], e + 1);

    // Synchronous reset in the middle of the stop bit
    repeat (2) @(negedge clk);
    mon_en_a = 1'b0;
    send(1, 8'h81, 1'b0, e);
    dv_a = 1'b0;
    while (cyc < e + 38) @(negedge clk);
    chk("rst_mid_stop_level", ser_a, 1);
    chk("rst_mid_stop_busy", busy_a, 1);
    rst = 1'b1;
    #1 chk("rst_mid_ready_low", ready_a, 0);
    @(negedge clk);
    chk("rst_mid_ser", ser_a, 1);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_ready", ready_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_ready", ready_a, 1);
    repeat (6) @(negedge clk);
    mon_en_a = 1'b1;

    // Idle hold
    ser_ok = 1'b1; busy_ok = 1'b1; rdy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ser_a !== 1'b1) ser_ok = 1'b0;
      if (busy_a !== 1'b0) busy_ok = 1'b0;
      if (ready_a !== 1'b1) rdy_ok = 1'b0;
    end
    chk("idle_ser", ser_ok, 1);
    chk("idle_busy", busy_ok, 0 + 1);
    chk("idle_ready", rdy_ok, 1);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    chk("frames_a_total", frames_a, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
